// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: opcode/flag/handshake inputs and control outputs of the multicycle control unit.
// Perf counter signals exist only when MULTICYCLE_CU_PERF_EN is defined.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 5
);
    logic [OPCODE_W-1:0] opcode;
    logic mem_ready, flag_z, flag_n, flag_c, flag_v;
    logic [ALU_OP_W-1:0] alu_op;
    logic alu_source, jump, ret, imm_pos, pc_or_data, mem_to_reg, write_address_DM;
    logic branch_zero, branch_negative, branch_carry, branch_overflow, branch_always;
    logic write_enable_DM, write_enable_RF, mem_req, ir_load, pc_load, pc_inc, alu_start;
    logic branch_taken, illegal_op, busy;
    logic [2:0] state;
`ifdef MULTICYCLE_CU_PERF_EN
    logic [31:0] instr_retired, cycle_count;
`endif
    modport master (
        input opcode, mem_ready, flag_z, flag_n, flag_c, flag_v,
        output alu_op, alu_source, jump, ret, imm_pos, pc_or_data, mem_to_reg, write_address_DM,
        output branch_zero, branch_negative, branch_carry, branch_overflow, branch_always,
        output write_enable_DM, write_enable_RF, mem_req, ir_load, pc_load, pc_inc, alu_start,
        output branch_taken, illegal_op, busy, state
`ifdef MULTICYCLE_CU_PERF_EN
        , output instr_retired, cycle_count
`endif
    );
    modport slave (
        output opcode, mem_ready, flag_z, flag_n, flag_c, flag_v,
        input alu_op, alu_source, jump, ret, imm_pos, pc_or_data, mem_to_reg, write_address_DM,
        input branch_zero, branch_negative, branch_carry, branch_overflow, branch_always,
        input write_enable_DM, write_enable_RF, mem_req, ir_load, pc_load, pc_inc, alu_start,
        input branch_taken, illegal_op, busy, state
`ifdef MULTICYCLE_CU_PERF_EN
        , input instr_retired, cycle_count
`endif
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a registered control word.
// Define MULTICYCLE_CU_PERF_EN to add the instr_retired/cycle_count counters.
module multicycle_control_unit #(
    parameter int OPCODE_W   = 6,
    parameter int ALU_OP_W   = 5,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input logic clk,
    input logic rst,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic alu_source, imm_pos, jump, ret, pc_or_data, mem_to_reg, write_address_DM;
        logic branch_zero, branch_negative, branch_carry, branch_overflow, branch_always;
        logic illegal_op;
    } cw_t;
    state_t cur, nxt;
    cw_t cw, d;
    logic fresh, ex_first, hi, flow, taken;
    logic [5:0] op;
    logic [3:0] cnt, d_len;
    assign op = bus.opcode[5:0];
    assign hi = |(bus.opcode >> 6);
    always_comb begin
        d = '0;
        d_len = 4'd1;
        if (hi) d.illegal_op = 1'b1;
        else if (op[5] || !op[4]) begin
            d.alu_op = ALU_OP_W'(op[4:0]);
            d.alu_source = op[5];
            d.imm_pos = op[5];
            d_len = op[4:0] == 5'd7 ? 4'(MUL_CYCLES) : (op[4:0] == 5'd8 || op[4:0] == 5'd9) ? 4'(DIV_CYCLES) : 4'd1;
        end else begin
            case (op[3:0])
                4'h0: d.jump = 1'b1;
                4'h1: d.branch_zero = 1'b1;
                4'h2: d.branch_carry = 1'b1;
                4'h3: d.branch_negative = 1'b1;
                4'h4: d.branch_overflow = 1'b1;
                4'h5: d.branch_always = 1'b1;
                4'h8: begin d.ret = 1'b1; d.pc_or_data = 1'b1; end
                4'h9: begin d.alu_source = 1'b1; d.mem_to_reg = 1'b1; end
                4'ha: begin d.alu_source = 1'b1; d.write_address_DM = 1'b1; end
                default: d.illegal_op = 1'b1;
            endcase
        end
    end
    // fresh masks FETCH strobes for the first cycle out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= FETCH;
            fresh <= 1'b1;
            ex_first <= 1'b0;
        end else begin
            cur <= nxt;
            fresh <= 1'b0;
            ex_first <= cur == DECODE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cw <= '0;
            cnt <= '0;
        end else if (cur == DECODE) begin
            cw <= d;
            cnt <= d_len - 4'd1;
        end else if (cur == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
    assign flow = cw.jump | cw.ret | cw.branch_zero | cw.branch_negative | cw.branch_carry | cw.branch_overflow | cw.branch_always;
    always_comb begin
        nxt = cur;
        case (cur)
            FETCH: nxt = (!fresh && bus.mem_ready) ? DECODE : FETCH;
            DECODE: nxt = EXEC;
            EXEC: nxt = cnt != 4'd0 ? EXEC : (flow || cw.illegal_op) ? FETCH : (cw.mem_to_reg || cw.write_address_DM) ? MEM : WB;
            MEM: nxt = !bus.mem_ready ? MEM : cw.write_address_DM ? FETCH : WB;
            default: nxt = FETCH;
        endcase
    end
    assign taken = cur == EXEC && ((cw.branch_zero & bus.flag_z) | (cw.branch_negative & bus.flag_n) |
        (cw.branch_carry & bus.flag_c) | (cw.branch_overflow & bus.flag_v) | cw.branch_always | cw.jump | cw.ret);
    always_comb begin
        bus.mem_req = (cur == FETCH && !fresh) || cur == MEM;
        bus.ir_load = cur == FETCH && !fresh && bus.mem_ready;
        bus.alu_start = cur == EXEC && ex_first;
        bus.branch_taken = taken;
        bus.pc_load = taken;
        bus.pc_inc = (cur == EXEC && (flow || cw.illegal_op) && !taken) ||
            (cur == MEM && cw.write_address_DM && bus.mem_ready) || cur == WB;
        bus.write_enable_DM = cur == MEM && cw.write_address_DM && bus.mem_ready;
        bus.write_enable_RF = cur == WB;
        bus.busy = cur != FETCH;
        bus.state = cur;
    end
    assign bus.alu_op = cw.alu_op;
    assign bus.alu_source = cw.alu_source;
    assign bus.imm_pos = cw.imm_pos;
    assign bus.jump = cw.jump;
    assign bus.ret = cw.ret;
    assign bus.pc_or_data = cw.pc_or_data;
    assign bus.mem_to_reg = cw.mem_to_reg;
    assign bus.write_address_DM = cw.write_address_DM;
    assign bus.branch_zero = cw.branch_zero;
    assign bus.branch_negative = cw.branch_negative;
    assign bus.branch_carry = cw.branch_carry;
    assign bus.branch_overflow = cw.branch_overflow;
    assign bus.branch_always = cw.branch_always;
    assign bus.illegal_op = cw.illegal_op;
`ifdef MULTICYCLE_CU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cycle_count <= '0;
            bus.instr_retired <= '0;
        end else begin
            bus.cycle_count <= bus.cycle_count + 32'd1;
            if (cur != FETCH && nxt == FETCH) bus.instr_retired <= bus.instr_retired + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction stream scored against a per-instruction reference table.
module tb_multicycle_control_unit;
    localparam int MULC = 3;
    localparam int DIVC = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    multicycle_control_unit_if #(.OPCODE_W(6), .ALU_OP_W(5)) bus ();
    multicycle_control_unit #(.OPCODE_W(6), .ALU_OP_W(5), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // cw bits: illegal, alu_op[4:0], alu_source, imm_pos, jump, ret, pc_or_data, mem_to_reg, wad, bz, bn, bc, bv, ba
    typedef struct {
        logic [17:0] cw;
        bit alu;
        bit taken;
        int lat;
        int rf;
        int dm;
    } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, n_ret = 0, ncyc = 0;
    bit saw_ir = 0, saw_start = 0, force_rdy = 1, drain_mode = 0;
    logic [5:0] nxt_op;
    logic [3:0] nxt_f;
    logic [5:0] special [14] = '{6'o20, 6'o21, 6'o22, 6'o23, 6'o24, 6'o25, 6'o30, 6'o31, 6'o32,
                                 6'o07, 6'o10, 6'o11, 6'o61, 6'o37};

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, want, $time);
        end
    endtask

    // f = {z, n, c, v}; lat counts cycles after the ir_load cycle, memory stalls excluded
    function automatic exp_t model(input logic [5:0] op, input logic [3:0] f);
        exp_t e;
        logic [4:0] a = op[4:0];
        e.cw = '0; e.alu = 0; e.taken = 0; e.lat = 2; e.rf = 0; e.dm = 0;
        if (op[5] || !op[4]) begin
            e.alu = 1; e.rf = 1;
            e.cw[16:12] = a; e.cw[11] = op[5]; e.cw[10] = op[5];
            e.lat = 2 + (a == 5'd7 ? MULC : (a == 5'd8 || a == 5'd9) ? DIVC : 1);
        end else begin
            case (op[3:0])
                4'd0: begin e.cw[9] = 1; e.taken = 1; end
                4'd1: begin e.cw[4] = 1; e.taken = f[3]; end
                4'd2: begin e.cw[2] = 1; e.taken = f[1]; end
                4'd3: begin e.cw[3] = 1; e.taken = f[2]; end
                4'd4: begin e.cw[1] = 1; e.taken = f[0]; end
                4'd5: begin e.cw[0] = 1; e.taken = 1; end
                4'd8: begin e.cw[8] = 1; e.cw[7] = 1; e.taken = 1; end
                4'd9: begin e.cw[11] = 1; e.cw[6] = 1; e.rf = 1; e.lat = 4; end
                4'd10: begin e.cw[11] = 1; e.cw[5] = 1; e.dm = 1; e.lat = 3; end
                default: e.cw[17] = 1;
            endcase
        end
        return e;
    endfunction

    function automatic logic [17:0] obs_cw();
        return {bus.illegal_op, bus.alu_op, bus.alu_source, bus.imm_pos, bus.jump, bus.ret, bus.pc_or_data,
                bus.mem_to_reg, bus.write_address_DM, bus.branch_zero, bus.branch_negative, bus.branch_carry,
                bus.branch_overflow, bus.branch_always};
    endfunction

    task automatic pick();
        nxt_op = $urandom_range(0, 9) < 5 ? special[$urandom_range(0, 13)] : 6'($urandom_range(0, 63));
        nxt_f = 4'($urandom);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (saw_ir) begin
            bus.opcode = nxt_op;
            {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = nxt_f;
            q.push_back(model(nxt_op, nxt_f));
            pick();
        end else bus.opcode = 6'($urandom);
        bus.mem_ready = drain_mode ? (bus.mem_req & bus.busy) : force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic chk_zero(input string n);
        chk(n, 32'({obs_cw(), bus.write_enable_DM, bus.write_enable_RF, bus.mem_req, bus.ir_load, bus.pc_load,
                    bus.pc_inc, bus.alu_start, bus.branch_taken, bus.busy, bus.state}), 32'd0);
`ifdef MULTICYCLE_CU_PERF_EN
        chk({n, "_retired"}, bus.instr_retired, 32'd0);
        chk({n, "_cycles"}, bus.cycle_count, 32'd0);
`endif
    endtask

    task automatic drain();
        drain_mode = 1;
        for (int i = 0; i < 80 && (q.size() != 0 || bus.busy); i++) cyc();
        repeat (3) cyc();
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        drain_mode = 0;
`ifdef MULTICYCLE_CU_PERF_EN
        @(negedge clk);
        #1;
        chk("perf_retired", bus.instr_retired, 32'(n_ret));
        chk("perf_cycles", bus.cycle_count, 32'(ncyc - 1));
`endif
    endtask

    initial begin : monitor
        int off = 0, st = 0, rf = 0, dm = 0, as = 0;
        bit act = 0;
        exp_t e;
        logic [17:0] m;
        forever begin
            @(negedge clk);
            saw_ir = bus.ir_load;
            if (bus.alu_start) saw_start = 1;
            if (rst) begin
                act = 0; n_ret = 0; ncyc = 0;
                continue;
            end
            ncyc++;
            chk("pc_load_pc_inc_excl", 32'(bus.pc_load & bus.pc_inc), 32'd0);
            chk("we_dm_we_rf_excl", 32'(bus.write_enable_DM & bus.write_enable_RF), 32'd0);
            if (bus.ir_load) begin
                chk("busy_in_fetch", 32'(bus.busy), 32'd0);
                act = 1; off = 0; st = 0; rf = 0; dm = 0; as = 0;
            end else if (act) begin
                off++;
                if (bus.mem_req && !bus.mem_ready) st++;
                rf += int'(bus.write_enable_RF);
                dm += int'(bus.write_enable_DM);
                as += int'(bus.alu_start);
                if (bus.pc_load || bus.pc_inc) begin
                    if (q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        m = e.alu ? 18'h3ffff : 18'h3ffff & ~18'h1f000;
                        chk("latency", 32'(off - st), 32'(e.lat));
                        chk("control_word", 32'(obs_cw() & m), 32'(e.cw & m));
                        chk("pc_load", 32'(bus.pc_load), 32'(e.taken));
                        chk("branch_taken", 32'(bus.branch_taken), 32'(e.taken));
                        chk("we_rf_count", 32'(rf), 32'(e.rf));
                        chk("we_dm_count", 32'(dm), 32'(e.dm));
                        chk("alu_start_count", 32'(as), 32'd1);
                        chk("busy_active", 32'(bus.busy), 32'd1);
                    end
                    n_ret++;
                    act = 0;
                end
            end else chk("idle_strobes", 32'({bus.pc_load, bus.pc_inc, bus.write_enable_RF, bus.write_enable_DM,
                                                bus.alu_start}), 32'd0);
        end
    end

    initial begin : driver
        bus.opcode = '0;
        bus.mem_ready = 1'b1;
        {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = '0;
        nxt_op = 6'o00;
        nxt_f = 4'($urandom);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("reset_state");
        cyc();
        @(negedge clk);
        #1;
        chk("ir_load_cycle1", 32'(bus.ir_load), 32'd1);
        repeat (4) cyc();
        force_rdy = 0;
        repeat (4000) cyc();
        drain();
        nxt_op = 6'o10;
        force_rdy = 1;
        saw_start = 0;
        for (int i = 0; i < 20 && !saw_start; i++) cyc();
        chk("div_reached_exec", 32'(saw_start), 32'd1);
        repeat (2) cyc();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        #1;
        chk_zero("reset_mid_div");
        force_rdy = 0;
        repeat (600) cyc();
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised, sequential successor of the combinational control unit.
- FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Registers the decoded control word for the whole instruction; drives one-cycle strobes to the PC, IR, register file and data memory.
- Stretches EXEC for multi-cycle ALU ops; waits on a memory ready handshake.

Parameters:
- OPCODE_W, 6, opcode width; supported values are 6 and above; bits above [5] must be 0 or the opcode is illegal.
- ALU_OP_W, 5, alu_op width; opcode[4:0] is zero-extended into it.
- MUL_CYCLES, 3, EXEC length for MUL (opcode[4:0]=00111), range 1..15.
- DIV_CYCLES, 8, EXEC length for DIV/MOD (opcode[4:0]=01000/01001), range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  from IR; sampled only in DECODE
- mem_ready  in  1  memory handshake, instruction and data
- flag_z/flag_n/flag_c/flag_v  in  1 each  ALU flags, sampled in EXEC
- alu_op  out  ALU_OP_W  registered
- alu_source, jump, ret, imm_pos, pc_or_data, mem_to_reg, write_address_DM  out  1 each  registered control word
- branch_zero/negative/carry/overflow/always  out  1 each  registered control word
- write_enable_DM, write_enable_RF  out  1  one-cycle strobes
- mem_req, ir_load, pc_load, pc_inc, alu_start  out  1  strobes/levels
- branch_taken  out  1  EXEC only
- illegal_op, busy  out  1
- state  out  3  FSM state, for debug

Behaviour:
- Reset (rst=1 at a clk edge, from any state, mid-instruction included):
  - state=FETCH, all outputs 0, cycle counter 0.
  - No strobe is issued in the cycle after reset.
- Decode, latched at the DECODE→EXEC edge:
  - 00xxxx: ALU register op; alu_op=opcode[4:0], alu_source=0.
  - 1xxxxx: ALU immediate op; alu_op=opcode[4:0], alu_source=1, imm_pos=1.
  - 010000 JMP: jump=1.
  - 010001 BRZ, 010010 BRC, 010011 BRN, 010100 BRV, 010101 BRA: set the matching branch_* bit.
  - 011000 RET: ret=1, pc_or_data=1.
  - 011001 LW: alu_source=1, mem_to_reg=1.
  - 011010 SW: alu_source=1, write_address_DM=1.
  - Any other opcode: illegal_op=1 for that instruction, behaves as NOP.
- FETCH: mem_req=1 until mem_ready; on mem_ready, ir_load=1 for that same cycle, next state DECODE.
- DECODE: 1 cycle; control word registered; busy=1 from here until return to FETCH.
- EXEC:
  - alu_start=1 on the first cycle.
  - MUL holds MUL_CYCLES cycles, DIV/MOD hold DIV_CYCLES cycles, all other ops 1 cycle. The down-counter loads on entry.
  - Branch/jump/RET: branch_taken = (branch_zero&flag_z)|(branch_negative&flag_n)|(branch_carry&flag_c)|(branch_overflow&flag_v)|branch_always|jump|ret.
    - If taken: pc_load=1; otherwise pc_inc=1. Next state FETCH.
  - LW/SW: next state MEM.
  - ALU ops: next state WB.
  - Illegal opcode: pc_inc=1, next state FETCH.
- MEM:
  - mem_req=1 until mem_ready.
  - SW: write_enable_DM=1 in the mem_ready cycle only; pc_inc=1 in that cycle; next state FETCH.
  - LW: next state WB on mem_ready.
- WB: write_enable_RF=1 and pc_inc=1 for exactly 1 cycle; next state FETCH.
- Latency with mem_ready held high:
  - ALU single-cycle op: 4 cycles.
  - MUL: 3+MUL_CYCLES cycles.
  - Branch: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Boundaries:
  - mem_ready arriving while the FSM is not in FETCH/MEM is ignored.
  - opcode changes outside DECODE have no effect.
  - pc_load and pc_inc are never both 1 in the same cycle.
  - write_enable_DM and write_enable_RF are never both 1 in the same cycle.
  - The EXEC counter never wraps; a new instruction reloads it.

Optional Feature:
- Macro: MULTICYCLE_CU_PERF_EN.
- Defined:
  - Adds outputs instr_retired[31:0] and cycle_count[31:0], both cleared by rst.
  - cycle_count increments every cycle.
  - instr_retired increments on the cycle the FSM returns to FETCH, illegal opcodes included.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then opcode=000000 (ADD), mem_ready=1 → ir_load at cycle 1, write_enable_RF=1 and pc_inc=1 at cycle 4, alu_op=00000, alu_source=0.
- MUL with MUL_CYCLES=3: opcode=000111 → alu_start 1 cycle, FSM in EXEC exactly 3 cycles, write_enable_RF on cycle 6; DIV 001000 holds 8 cycles.
- Branches:
  - BRN 010011 with flag_n=1 → branch_negative=1, branch_taken=1, pc_load=1 at cycle 3, write_enable_RF never asserted.
  - Same opcode with flag_n=0 → pc_inc=1 instead.
- SW 011010 with mem_ready low for 2 cycles in MEM → mem_req held; write_enable_DM=1 for exactly 1 cycle, when mem_ready rises.
- Immediate and illegal opcodes:
  - DEC immediate 110001 → alu_op=10001, alu_source=1, imm_pos=1.
  - 011111 → illegal_op=1, pc_inc=1 at cycle 3, no writes.
- Reset mid-op: rst=1 during EXEC of DIV → next cycle state=FETCH, all outputs 0, no write_enable_RF. With MULTICYCLE_CU_PERF_EN defined: instr_retired=0 and cycle_count=0.
